dma_window_responder: RTL and testbench

Responder end of the controller↔DMA request handshake used by the CNN top level. It accepts one request at a time (read a strided 5×5 window, write one result word, load a 5×5 filter, or load one bias), executes it as single-word accesses on the RAM port, and signals completion with a four-phase start/finish handshake. It sits between the CNN controller, the RAM and the filter buffer.

---
 rtl/dma_pkg.sv | 39 +++
 rtl/dma_addr_gen.sv | 78 +++++++
 rtl/dma_window_responder.sv | 157 +++++++++++++++
 tb/tb_dma_window_responder.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared constants and types for the DMA window responder.
//   DW / AW      : data and address widths
//   WIN / WORDS  : window edge and words per window (WIN*WIN)
//   mode_e       : request kinds issued by the CNN controller
//   state_e      : responder FSM states
package dma_pkg;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 16;
    localparam int unsigned WIN   = 5;
    localparam int unsigned WORDS = WIN * WIN;
    localparam int unsigned CW    = $clog2(WIN);
    localparam int unsigned KW    = $clog2(WORDS);

    localparam logic [CW-1:0] LAST_COL = CW'(WIN - 1);
    localparam logic [KW-1:0] LAST_IDX = KW'(WORDS - 1);
    localparam logic [AW-1:0] WORDS_AW = AW'(WORDS);

    typedef enum logic [1:0] {
        MODE_READ_WIN    = 2'd0,
        MODE_WRITE       = 2'd1,
        MODE_LOAD_FILTER = 2'd2,
        MODE_LOAD_BIAS   = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_FB_WR,
        ST_DONE
    } state_e;

    // Requests whose data ends up in the filter buffer rather than the window.
    function automatic logic mode_uses_fb(mode_e m);
        return (m == MODE_LOAD_FILTER) || (m == MODE_LOAD_BIAS);
    endfunction

endpackage

// File: rtl/dma_addr_gen.sv
// Word counters and address computation for one DMA request.
//   clk, reset   : clock, synchronous active-high reset
//   clear        : restart counters at word 0 (new request)
//   advance      : current word completed, step to the next
//   mode         : request kind (dma_pkg::mode_e encoding)
//   base, offset : base address and row stride
//   filter_num   : filter/bias slot index
//   addr         : address of the current word (wraps mod 2^AW)
//   index        : linear word index 0..WORDS-1
//   last         : current word is the final one of the request
module dma_addr_gen
    import dma_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          advance,
    input  logic [1:0]    mode,
    input  logic [AW-1:0] base,
    input  logic [AW-1:0] offset,
    input  logic [15:0]   filter_num,
    output logic [AW-1:0] addr,
    output logic [KW-1:0] index,
    output logic          last
);

    logic [CW-1:0] col_q;
    logic [KW-1:0] idx_q;
    // Accumulated r*offset, so no multiplier is needed on the stride.
    logic [AW-1:0] row_off_q;
    logic [AW-1:0] filt_base;
    mode_e         mode_t;

    assign mode_t    = mode_e'(mode);
    assign filt_base = AW'(filter_num) * WORDS_AW;
    assign index     = idx_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            col_q     <= '0;
            idx_q     <= '0;
            row_off_q <= '0;
        end else if (advance) begin
            idx_q <= idx_q + KW'(1);
            if (col_q == LAST_COL) begin
                col_q     <= '0;
                row_off_q <= row_off_q + offset;
            end else begin
                col_q <= col_q + CW'(1);
            end
        end
    end

    always_comb begin
        addr = base;
        last = 1'b1;
        unique case (mode_t)
            MODE_READ_WIN: begin
                addr = base + row_off_q + AW'(col_q);
                last = (idx_q == LAST_IDX);
            end
            MODE_WRITE: begin
                addr = base;
            end
            MODE_LOAD_FILTER: begin
                addr = base + filt_base + AW'(idx_q);
                last = (idx_q == LAST_IDX);
            end
            MODE_LOAD_BIAS: begin
                addr = base + AW'(filter_num);
            end
            default: begin
                addr = base;
            end
        endcase
    end

endmodule

// File: rtl/dma_window_responder.sv
// Responder side of the controller<->DMA start/finish handshake. Executes one
// request at a time as single-word RAM accesses and reports completion.
//   clk, reset          : clock, synchronous active-high reset
//   req_start/finish    : four-phase request handshake
//   req_mode/addr/...   : request parameters, latched when accepted
//   win_data            : last 5x5 window read, element r*WIN+c
//   mem_en/we/addr/...  : single-outstanding RAM port, mem_ack ends an access
//   fb_we/sel/index/... : filter-buffer write port (filter or bias)
module dma_window_responder
    import dma_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_start,
    output logic                  req_finish,
    input  logic [1:0]            req_mode,
    input  logic [AW-1:0]         req_addr,
    input  logic [AW-1:0]         req_offset,
    input  logic [15:0]           req_filter_num,
    input  logic [DW-1:0]         req_wdata,
    output logic [WORDS*DW-1:0]   win_data,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [AW-1:0]         mem_addr,
    output logic [DW-1:0]         mem_wdata,
    input  logic [DW-1:0]         mem_rdata,
    input  logic                  mem_ack,
    output logic                  fb_we,
    output logic                  fb_sel,
    output logic [15:0]           fb_index,
    output logic [WORDS*DW-1:0]   fb_filter,
    output logic [DW-1:0]         fb_bias
);

    state_e state_q, state_d;
    mode_e  mode_q;

    logic [AW-1:0]       addr_q;
    logic [AW-1:0]       offset_q;
    logic [15:0]         fnum_q;
    logic [DW-1:0]       wdata_q;
    logic                finish_q;
    logic [WORDS*DW-1:0] win_q;
    logic [WORDS*DW-1:0] filter_q;
    logic [DW-1:0]       bias_q;

    logic          latch;
    logic          ag_advance;
    logic [AW-1:0] ag_addr;
    logic [KW-1:0] ag_index;
    logic          ag_last;

    dma_addr_gen u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .clear      (latch),
        .advance    (ag_advance),
        .mode       (mode_q),
        .base       (addr_q),
        .offset     (offset_q),
        .filter_num (fnum_q),
        .addr       (ag_addr),
        .index      (ag_index),
        .last       (ag_last)
    );

    always_comb begin
        state_d    = state_q;
        latch      = 1'b0;
        ag_advance = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_start) begin
                    latch   = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_ack) begin
                    ag_advance = 1'b1;
                    if (!ag_last) begin
                        state_d = ST_ISSUE;
                    end else if (mode_uses_fb(mode_q)) begin
                        state_d = ST_FB_WR;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_FB_WR: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!req_start) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The access strobe lives only in ISSUE, so it can never appear while
    // an access is still waiting for its ack.
    assign mem_en    = (state_q == ST_ISSUE);
    assign mem_we    = mem_en && (mode_q == MODE_WRITE);
    assign mem_addr  = mem_en ? ag_addr : '0;
    assign mem_wdata = mem_we ? wdata_q : '0;

    assign fb_we    = (state_q == ST_FB_WR);
    assign fb_sel   = fb_we && (mode_q == MODE_LOAD_BIAS);
    assign fb_index = fb_we ? fnum_q : '0;

    assign req_finish = finish_q;
    assign win_data   = win_q;
    assign fb_filter  = filter_q;
    assign fb_bias    = bias_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_READ_WIN;
            addr_q   <= '0;
            offset_q <= '0;
            fnum_q   <= '0;
            wdata_q  <= '0;
            finish_q <= 1'b0;
            win_q    <= '0;
            filter_q <= '0;
            bias_q   <= '0;
        end else begin
            state_q <= state_d;
            // Finish drops the cycle after req_start is seen low in DONE.
            finish_q <= (state_q == ST_DONE) && req_start;
            if (latch) begin
                mode_q   <= mode_e'(req_mode);
                addr_q   <= req_addr;
                offset_q <= req_offset;
                fnum_q   <= req_filter_num;
                wdata_q  <= req_wdata;
            end
            if ((state_q == ST_WAIT) && mem_ack) begin
                unique case (mode_q)
                    MODE_READ_WIN:    win_q[int'(ag_index) * DW +: DW]    <= mem_rdata;
                    MODE_LOAD_FILTER: filter_q[int'(ag_index) * DW +: DW] <= mem_rdata;
                    MODE_LOAD_BIAS:   bias_q <= mem_rdata;
                    default:          ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dma_window_responder.sv
module tb_dma_window_responder;
    import dma_pkg::*;

    localparam int NW = WORDS;

    logic                clk = 1'b0;
    logic                reset;
    logic                req_start;
    logic                req_finish;
    logic [1:0]          req_mode;
    logic [AW-1:0]       req_addr;
    logic [AW-1:0]       req_offset;
    logic [15:0]         req_filter_num;
    logic [DW-1:0]       req_wdata;
    logic [NW*DW-1:0]    win_data;
    logic                mem_en;
    logic                mem_we;
    logic [AW-1:0]       mem_addr;
    logic [DW-1:0]       mem_wdata;
    logic [DW-1:0]       mem_rdata;
    logic                mem_ack;
    logic                fb_we;
    logic                fb_sel;
    logic [15:0]         fb_index;
    logic [NW*DW-1:0]    fb_filter;
    logic [DW-1:0]       fb_bias;

    always #5 clk = ~clk;

    dma_window_responder dut (
        .clk            (clk),
        .reset          (reset),
        .req_start      (req_start),
        .req_finish     (req_finish),
        .req_mode       (req_mode),
        .req_addr       (req_addr),
        .req_offset     (req_offset),
        .req_filter_num (req_filter_num),
        .req_wdata      (req_wdata),
        .win_data       (win_data),
        .mem_en         (mem_en),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_ack        (mem_ack),
        .fb_we          (fb_we),
        .fb_sel         (fb_sel),
        .fb_index       (fb_index),
        .fb_filter      (fb_filter),
        .fb_bias        (fb_bias)
    );

    // Edge counter: after posedge n, cyc == n.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model with RAM[a] = a, ack L cycles after the cycle mem_en is seen.
    logic [DW-1:0] ram [65536];
    int            mem_lat = 1;
    logic          pend;
    int            cnt;
    logic [AW-1:0] pa;

    always @(posedge clk) begin
        if (reset) begin
            for (int a = 0; a < 65536; a++) ram[a] <= DW'(a);
            mem_ack   <= 1'b0;
            mem_rdata <= '0;
            pend      <= 1'b0;
            cnt       <= 0;
            pa        <= '0;
        end else begin
            mem_ack <= 1'b0;
            if (mem_en) begin
                if (mem_we) ram[mem_addr] <= mem_wdata;
                if (mem_lat <= 1) begin
                    mem_ack   <= 1'b1;
                    mem_rdata <= ram[mem_addr];
                end else begin
                    pend <= 1'b1;
                    cnt  <= mem_lat - 1;
                    pa   <= mem_addr;
                end
            end else if (pend) begin
                if (cnt == 1) begin
                    mem_ack   <= 1'b1;
                    mem_rdata <= ram[pa];
                    pend      <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end
        end
    end

    // Scoreboard records.
    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] data;
        int            gap;
    } acc_t;

    typedef struct {
        logic          sel;
        logic [15:0]   idx;
        logic [DW-1:0] f0;
        logic [DW-1:0] f24;
        logic [DW-1:0] bias;
        logic          is_bias;
    } fb_t;

    typedef struct {
        int               fin_edge;
        logic [NW*DW-1:0] win;
    } fin_t;

    acc_t acc_q[$];
    fb_t  fb_q[$];
    fin_t fin_q[$];

    logic [NW*DW-1:0] exp_win = '0;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [NW*DW-1:0] got,
                       input logic [NW*DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents an event.
    acc_t ma;
    fb_t  mf;
    fin_t mfin;
    logic fin_prev    = 1'b0;
    int   last_en_cyc = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (mem_en) begin
                if (acc_q.size() == 0) begin
                    chk("unexpected_access", {mem_we, mem_addr}, '0);
                end else begin
                    ma = acc_q.pop_front();
                    chk("mem_addr", mem_addr, ma.addr);
                    chk("mem_we", mem_we, ma.we);
                    if (ma.we) chk("mem_wdata", mem_wdata, ma.data);
                    if (ma.gap > 0) chk("access_gap", cyc - last_en_cyc, ma.gap);
                end
                last_en_cyc = cyc;
            end
            if (fb_we) begin
                if (fb_q.size() == 0) begin
                    chk("unexpected_fb_we", fb_we, 1'b0);
                end else begin
                    mf = fb_q.pop_front();
                    chk("fb_sel", fb_sel, mf.sel);
                    chk("fb_index", fb_index, mf.idx);
                    if (mf.is_bias) begin
                        chk("fb_bias_word", fb_bias, mf.bias);
                    end else begin
                        chk("fb_filter_first", fb_filter[0 +: DW], mf.f0);
                        chk("fb_filter_last", fb_filter[(NW-1)*DW +: DW], mf.f24);
                    end
                end
            end
            if (req_finish && !fin_prev) begin
                if (fin_q.size() == 0) begin
                    chk("unexpected_finish", req_finish, 1'b0);
                end else begin
                    mfin = fin_q.pop_front();
                    chk("finish_edge", cyc, mfin.fin_edge);
                    chk("win_data", win_data, mfin.win);
                end
            end
            fin_prev = req_finish;
        end
    end

    // Issue one request, queue its expected accesses/fb write/finish.
    task automatic do_req(input logic [1:0] mode, input logic [AW-1:0] addr,
                          input logic [AW-1:0] off, input logic [15:0] fnum,
                          input logic [DW-1:0] wd, input int lat);
        acc_t          a;
        fb_t           f;
        fin_t          fe;
        int            words;
        int            start;
        int            n;
        logic [AW-1:0] ad;
        mem_lat = lat;
        words   = 0;
        case (mode)
            2'd0: begin
                for (int r = 0; r < WIN; r++) begin
                    for (int c = 0; c < WIN; c++) begin
                        ad     = addr + AW'(r) * off + AW'(c);
                        a.addr = ad; a.we = 1'b0; a.data = '0;
                        a.gap  = (words == 0) ? 0 : 1 + lat;
                        acc_q.push_back(a);
                        exp_win[(r*WIN+c)*DW +: DW] = ad;
                        words++;
                    end
                end
            end
            2'd1: begin
                a.addr = addr; a.we = 1'b1; a.data = wd; a.gap = 0;
                acc_q.push_back(a);
                words = 1;
            end
            2'd2: begin
                for (int k = 0; k < NW; k++) begin
                    ad     = addr + fnum * 16'd25 + AW'(k);
                    a.addr = ad; a.we = 1'b0; a.data = '0;
                    a.gap  = (k == 0) ? 0 : 1 + lat;
                    acc_q.push_back(a);
                    words++;
                end
                f.sel = 1'b0; f.idx = fnum; f.is_bias = 1'b0; f.bias = '0;
                f.f0  = addr + fnum * 16'd25;
                f.f24 = addr + fnum * 16'd25 + 16'd24;
                fb_q.push_back(f);
            end
            default: begin
                ad     = addr + fnum;
                a.addr = ad; a.we = 1'b0; a.data = '0; a.gap = 0;
                acc_q.push_back(a);
                words = 1;
                f.sel = 1'b1; f.idx = fnum; f.is_bias = 1'b1; f.bias = ad;
                f.f0  = '0; f.f24 = '0;
                fb_q.push_back(f);
            end
        endcase

        @(negedge clk);
        req_mode       = mode;
        req_addr       = addr;
        req_offset     = off;
        req_filter_num = fnum;
        req_wdata      = wd;
        req_start      = 1'b1;
        start          = cyc + 1;
        fe.fin_edge    = start + 1 + words * (1 + lat) + ((mode >= 2'd2) ? 1 : 0);
        fe.win         = exp_win;
        fin_q.push_back(fe);

        n = 0;
        while (!req_finish && n < 1000) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                // Request fields must already be latched.
                req_mode       = ~mode;
                req_addr       = 16'hDEAD;
                req_offset     = 16'h0BAD;
                req_filter_num = 16'h7777;
                req_wdata      = 16'h5A5A;
            end
        end
        if (!req_finish) chk("finish_timeout", 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        chk("finish_hold", req_finish, 1'b1);
        req_start = 1'b0;
        @(negedge clk);
        chk("finish_fall", req_finish, 1'b0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ctrl"}, {req_finish, mem_en, mem_we, fb_we, fb_sel}, '0);
        chk({tag, "_addr"}, {mem_addr, mem_wdata, fb_index, fb_bias}, '0);
        chk({tag, "_win"}, win_data, '0);
        chk({tag, "_filter"}, fb_filter, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        acc_t a;
        int   start;
        reset          = 1'b1;
        req_start      = 1'b0;
        req_mode       = '0;
        req_addr       = '0;
        req_offset     = '0;
        req_filter_num = '0;
        req_wdata      = '0;
        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        reset = 1'b0;
        @(negedge clk);

        // Strided window read.
        do_req(2'd0, 16'd100, 16'd32, 16'd0, 16'd0, 1);
        chk("win_elem6", win_data[6*DW +: DW], 16'd133);
        chk("win_elem24", win_data[24*DW +: DW], 16'd232);

        // Single write, window untouched.
        do_req(2'd1, 16'h1234, 16'd0, 16'd0, 16'hBEEF, 1);
        chk("ram_write", ram[16'h1234], 16'hBEEF);

        // Filter load, slot 3.
        do_req(2'd2, 16'd0, 16'd0, 16'd3, 16'd0, 1);
        chk("filter_elem0", fb_filter[0 +: DW], 16'd75);
        chk("filter_elem24", fb_filter[24*DW +: DW], 16'd99);

        // Bias load, slot 5.
        do_req(2'd3, 16'd50550, 16'd0, 16'd5, 16'd0, 1);
        chk("bias_value", fb_bias, 16'd50555);

        // Address wrap with slower memory.
        do_req(2'd0, 16'hFFFE, 16'd1, 16'd0, 16'd0, 3);
        chk("wrap_elem1", win_data[1*DW +: DW], 16'hFFFF);
        chk("wrap_elem4", win_data[4*DW +: DW], 16'h0002);

        // Reset during the wait of word 10 of a window read.
        mem_lat = 1;
        for (int k = 0; k <= 10; k++) begin
            a.addr = AW'((k / WIN) * 8 + (k % WIN));
            a.we   = 1'b0;
            a.data = '0;
            a.gap  = (k == 0) ? 0 : 2;
            acc_q.push_back(a);
        end
        @(negedge clk);
        req_mode   = 2'd0;
        req_addr   = 16'd0;
        req_offset = 16'd8;
        req_start  = 1'b1;
        start      = cyc + 1;
        while (cyc < start + 21) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_state("midreset");
        reset     = 1'b0;
        req_start = 1'b0;
        exp_win   = '0;
        repeat (6) @(negedge clk);
        chk("midreset_drain", acc_q.size(), 0);
        chk("midreset_idle", {mem_en, req_finish, fb_we}, '0);

        // Normal request after the abort.
        do_req(2'd0, 16'd500, 16'd10, 16'd0, 16'd0, 1);
        chk("after_reset_elem7", win_data[7*DW +: DW], 16'd512);

        repeat (3) @(negedge clk);
        chk("queues_empty", acc_q.size() + fb_q.size() + fin_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
